// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW hazard, branch-penalty and STOP control for PC, decode IR and bubble insertion
module hazard_stall_ctrl #(
  parameter int DEPTH      = 2,
  parameter int HAZ_WIN    = 2,
  parameter int BR_PENALTY = 3,
  parameter int FWD        = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         id_instr,
  input  logic               id_valid,
  input  logic [8*DEPTH-1:0] older_instr,
  input  logic [DEPTH-1:0]   older_valid,
  output logic               pc_write,
  output logic               ir_load,
  output logic               bubble,
  output logic               counter_on,
  output logic               halted
);
  typedef enum logic [2:0] {IDLE, RUN, STALL, BRANCH, HALT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx, n;
  logic mask, mask_nx, br, stop, haz;
  logic [DEPTH-1:0] hz;
  logic [2:0] dst [DEPTH];
  // {writes, register} for an instruction; ori always targets k1
  function automatic logic [2:0] dest(input logic [7:0] i);
    return i[2:0] == 3'b111 ? 3'b101 :
           (i[3:0] == 4'b0000 || i[3:0] == 4'b0100 || i[3:0] == 4'b0110 ||
            i[3:0] == 4'b1000 || i[2:0] == 3'b011) ? {1'b1, i[7:6]} : 3'b000;
  endfunction
  // does instruction i read register r
  function automatic logic reads(input logic [7:0] i, input logic [1:0] r);
    logic r1, r2;
    r1 = i[3:0] == 4'b0010 || i[3:0] == 4'b0100 || i[3:0] == 4'b0110 ||
         i[3:0] == 4'b1000 || i[2:0] == 3'b011;
    r2 = i[3:0] == 4'b0000 || i[3:0] == 4'b0010 || i[3:0] == 4'b0100 ||
         i[3:0] == 4'b0110 || i[3:0] == 4'b1000;
    return (r1 && i[7:6] == r) || (r2 && i[5:4] == r) || (i[2:0] == 3'b111 && r == 2'b01);
  endfunction
  assign br   = id_valid && id_instr[1:0] == 2'b01 && id_instr[3:2] != 2'b00;
  assign stop = id_valid && id_instr[3:0] == 4'b0001;
  // per-slot hazard flags and stall length from the nearest hazarding producer
  always_comb begin
    hz = '0;
    n  = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      dst[k] = dest(older_instr[8*k +: 8]);
      hz[k]  = older_valid[k] && id_valid && dst[k][2] && reads(id_instr, dst[k][1:0]) &&
               k < HAZ_WIN && (FWD == 0 || (k == 0 && older_instr[8*k +: 4] == 4'b0000));
    end
    for (int k = DEPTH - 1; k >= 0; k--)
      if (hz[k]) n = FWD != 0 ? 3'd1 : 3'(HAZ_WIN - k);
  end
  assign haz = |hz && !mask;
  // next state, counter, progress mask and control outputs
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mask_nx    = mask;
    pc_write   = 1'b0;
    ir_load    = 1'b0;
    bubble     = 1'b0;
    counter_on = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        state_nx = RUN;
        mask_nx  = 1'b0;
      end
      RUN: begin
        counter_on = 1'b1;
        mask_nx    = 1'b0;
        if (stop) state_nx = HALT;
        else if (br) begin
          ir_load  = 1'b1;
          state_nx = BRANCH;
          cnt_nx   = 3'(BR_PENALTY);
        end else if (haz) begin
          bubble = 1'b1;
          if (n > 3'd1) begin
            state_nx = STALL;
            cnt_nx   = n - 3'd1;
          end else mask_nx = 1'b1;
        end else begin
          pc_write = 1'b1;
          ir_load  = 1'b1;
        end
      end
      STALL: begin
        counter_on = 1'b1;
        bubble     = 1'b1;
        cnt_nx     = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nx = RUN;
          mask_nx  = 1'b1;
        end
      end
      BRANCH: begin
        counter_on = 1'b1;
        ir_load    = 1'b1;
        pc_write   = cnt == 3'd1;
        cnt_nx     = cnt - 3'd1;
        if (cnt <= 3'd1) state_nx = RUN;
      end
      HALT: halted = 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  // state register; reset abandons any stall or branch in progress
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      mask  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      mask  <= mask_nx;
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed tests of stall, forwarding, branch, halt and reset behaviour
module tb_hazard_stall_ctrl;
  logic clock = 1'b0, reset = 1'b0, id_valid = 1'b0;
  logic [7:0] id_instr = 8'h00;
  logic [15:0] older_instr = 16'h0000;
  logic [1:0] older_valid = 2'b00;
  logic pw0, il0, bb0, co0, ht0, pw1, il1, bb1, co1, ht1;
  int checks = 0, passes = 0;
  wire [4:0] o0 = {pw0, il0, bb0, co0, ht0};
  wire [4:0] o1 = {pw1, il1, bb1, co1, ht1};
  localparam logic [4:0] OFF = 5'b00000, ADV = 5'b11010, STL = 5'b00110,
                         BRD = 5'b01010, STP = 5'b00010, HLT = 5'b00001;

  hazard_stall_ctrl #(.DEPTH(2), .HAZ_WIN(2), .BR_PENALTY(3), .FWD(0)) dut0 (
    .clock(clock), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .older_instr(older_instr), .older_valid(older_valid),
    .pc_write(pw0), .ir_load(il0), .bubble(bb0), .counter_on(co0), .halted(ht0));
  hazard_stall_ctrl #(.DEPTH(2), .HAZ_WIN(2), .BR_PENALTY(3), .FWD(1)) dut1 (
    .clock(clock), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .older_instr(older_instr), .older_valid(older_valid),
    .pc_write(pw1), .ir_load(il1), .bubble(bb1), .counter_on(co1), .halted(ht1));

  always #5 clock = ~clock;

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic set(input logic [7:0] id, input logic v, input logic [7:0] s0,
                     input logic [7:0] s1, input logic [1:0] ov);
    id_instr = id; id_valid = v; older_instr = {s1, s0}; older_valid = ov;
  endtask

  task automatic do_reset();
    set(8'h00, 1'b0, 8'h00, 8'h00, 2'b00);
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o0 !== OFF) $display("FAIL reset_f0: got %b want %b", o0, OFF); else passes++;
    checks++; if (o1 !== OFF) $display("FAIL reset_f1: got %b want %b", o1, OFF); else passes++;
    nxt(); reset = 1'b1;
    @(negedge clock);
    checks++; if (o0 !== OFF) $display("FAIL idle: got %b want %b", o0, OFF); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL first_run: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_stall_slot0();
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL s0_detect: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL s0_stall2: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL s0_masked: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL s0_after: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_stall_slot1();
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h14, 2'b10); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL s1_detect: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL s1_masked: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h14, 2'b00); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL s1_after: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_stall_both();
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h14, 2'b11); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL both_detect: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL both_stall2: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL both_masked: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL both_after: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_fwd();
    do_reset();
    set(8'h84, 1'b1, 8'h14, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o1 !== ADV) $display("FAIL fwd_alu: got %b want %b", o1, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h10, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o1 !== STL) $display("FAIL fwd_load: got %b want %b", o1, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o1 !== ADV) $display("FAIL fwd_load_masked: got %b want %b", o1, ADV); else passes++;
    nxt(); set(8'h94, 1'b1, 8'h07, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o1 !== ADV) $display("FAIL fwd_ori: got %b want %b", o1, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h00, 8'h10, 2'b10); @(negedge clock);
    checks++; if (o1 !== ADV) $display("FAIL fwd_load_slot1: got %b want %b", o1, ADV); else passes++;
  endtask

  task automatic test_branch();
    do_reset();
    set(8'h05, 1'b0, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL br_invalid: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h05, 1'b1, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== BRD) $display("FAIL br_detect: got %b want %b", o0, BRD); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== BRD) $display("FAIL br_cyc2: got %b want %b", o0, BRD); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== BRD) $display("FAIL br_cyc3: got %b want %b", o0, BRD); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL br_last: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL br_run: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_stop_halt();
    nxt(); set(8'h01, 1'b1, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== STP) $display("FAIL stop_detect: got %b want %b", o0, STP); else passes++;
    for (int i = 0; i < 20; i++) begin
      nxt(); set(8'h84, 1'b1, 8'h14, 8'h00, 2'(i)); @(negedge clock);
      checks++; if (o0 !== HLT) $display("FAIL halt_hold%0d: got %b want %b", i, o0, HLT); else passes++;
    end
    reset = 1'b0; #1;
    checks++; if (o0 !== OFF) $display("FAIL halt_reset: got %b want %b", o0, OFF); else passes++;
    nxt(); reset = 1'b1; set(8'h00, 1'b0, 8'h00, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== OFF) $display("FAIL halt_idle: got %b want %b", o0, OFF); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL halt_run: got %b want %b", o0, ADV); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL ms_detect: got %b want %b", o0, STL); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL ms_stall2: got %b want %b", o0, STL); else passes++;
    reset = 1'b0; #1;
    checks++; if (o0 !== OFF) $display("FAIL ms_reset: got %b want %b", o0, OFF); else passes++;
    nxt(); reset = 1'b1; set(8'h84, 1'b1, 8'h14, 8'h00, 2'b00); @(negedge clock);
    checks++; if (o0 !== OFF) $display("FAIL ms_idle: got %b want %b", o0, OFF); else passes++;
    nxt(); @(negedge clock);
    checks++; if (o0 !== ADV) $display("FAIL ms_run: got %b want %b", o0, ADV); else passes++;
    nxt(); set(8'h84, 1'b1, 8'h14, 8'h00, 2'b01); @(negedge clock);
    checks++; if (o0 !== STL) $display("FAIL ms_unmasked: got %b want %b", o0, STL); else passes++;
  endtask

  initial begin
    test_reset();
    test_stall_slot0();
    test_stall_slot1();
    test_stall_both();
    test_fwd();
    test_branch();
    test_stop_halt();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
